uart_rx_sampler: RTL and testbench

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

---
 rtl/uart_rx_sampler.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_sampler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 8N1 UART receiver with mid-bit sampling, a single-byte
// holding register, and sticky framing-error and overrun flags.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic       uart_rx,
  input  logic       uart_rd_i,
  output logic [7:0] uart_dat_o,
  output logic       done,
  output logic       uart_rx_busy,
  output logic       frame_err_o,
  output logic       overrun_o
);

  // The timer must be able to hold CLKS_PER_BIT-1.
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [2:0]    index, index_next;
  logic [7:0]    shift, shift_next;
  logic          rx_meta, rxs;
  logic [7:0]    dat_next;
  logic          done_next, frame_err_next, overrun_next;
  logic          good_frame, bad_frame, rd_ack;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  // Receiver state, timing counters and the user-visible holding register.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state       <= IDLE;
      timer       <= '0;
      index       <= '0;
      shift       <= '0;
      uart_dat_o  <= '0;
      done        <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      index       <= index_next;
      shift       <= shift_next;
      uart_dat_o  <= dat_next;
      done        <= done_next;
      frame_err_o <= frame_err_next;
      overrun_o   <= overrun_next;
    end
  end

  // Next-state logic: frame sequencing, bit sampling and flag updates.
  always_comb begin
    state_next     = state;
    timer_next     = timer;
    index_next     = index;
    shift_next     = shift;
    good_frame     = 1'b0;
    bad_frame      = 1'b0;
    dat_next       = uart_dat_o;
    done_next      = done;
    frame_err_next = frame_err_o;
    overrun_next   = overrun_o;

    case (state)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          timer_next = '0;
        end
      end
      START: begin
        if (timer == HALF_LAST) begin
          timer_next = '0;
          if (!rxs) begin
            state_next = DATA;
            index_next = '0;
          end else begin
            // Too short to be a start bit: treat as a glitch.
            state_next = IDLE;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      DATA: begin
        if (timer == BIT_LAST) begin
          timer_next        = '0;
          shift_next[index] = rxs;
          if (index == 3'd7) begin
            state_next = STOP;
          end else begin
            index_next = index + 3'd1;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      STOP: begin
        if (timer == BIT_LAST) begin
          timer_next = '0;
          if (rxs) begin
            // Leaving at mid-stop lets a back-to-back start bit be caught.
            good_frame = 1'b1;
            state_next = IDLE;
          end else begin
            bad_frame  = 1'b1;
            state_next = WAIT_HIGH;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      WAIT_HIGH: begin
        // A break holds the line low; only a return to high re-arms IDLE.
        if (rxs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Read handshake only acts when there is something to acknowledge.
    rd_ack = uart_rd_i && done;
    if (rd_ack) begin
      done_next      = 1'b0;
      frame_err_next = 1'b0;
      overrun_next   = 1'b0;
    end
    if (good_frame) begin
      dat_next  = shift;
      done_next = 1'b1;
      if (done && !uart_rd_i) begin
        overrun_next = 1'b1;
      end
    end
    if (bad_frame) begin
      frame_err_next = 1'b1;
    end
  end

  assign uart_rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Testbench for uart_rx_sampler: drives 8N1 frames at 434 clocks/bit and
// checks received bytes against a scoreboard plus the flag behaviour.
module tb_uart_rx_sampler;

  localparam int CPB = 434;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dat;
  logic       done;
  logic       busy;
  logic       ferr;
  logic       ovr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_rises = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  logic       prev_done = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_rx_sampler #(.CLKS_PER_BIT(CPB)) dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst_n),
    .uart_rx     (rx),
    .uart_rd_i   (rd),
    .uart_dat_o  (dat),
    .done        (done),
    .uart_rx_busy(busy),
    .frame_err_o (ferr),
    .overrun_o   (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every byte the DUT presents: a new done, or a changed byte while done.
  always @(negedge clk) begin
    if (done && (!prev_done || dat !== prev_dat)) begin
      got_q.push_back(dat);
      $display("[%0d] rx byte 0x%02h overrun=%0b", cyc, dat, ovr);
    end
    if (done && !prev_done) begin
      done_rises++;
      rise_cyc = cyc;
    end
    prev_done = done;
    prev_dat  = dat;
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    if (stop_bit) exp_q.push_back(d);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dat !== 8'h00) begin failures++; $display("FAIL reset_dat got=%h exp=00", dat); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", ferr); end
    checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", ovr); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    $display("[%0d] reset done", cyc);
  endtask

  task automatic test_basic();
    int delay;
    logic [7:0] e, g;
    exp_q.delete(); got_q.delete();
    send_frame(8'h75, 1'b1);
    repeat (CPB) @(negedge clk);
    // Observation happens at the negedge after the rising edge, so the
    // count includes that half cycle.
    delay = rise_cyc - fall_cyc;
    checks++; if (dat !== 8'h75) begin failures++; $display("FAIL basic_dat got=%h exp=75", dat); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", done); end
    checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL basic_ferr got=%b exp=0", ferr); end
    checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL basic_ovr got=%b exp=0", ovr); end
    checks++;
    if (delay < (19 * CPB) / 2 - 3 || delay > (19 * CPB) / 2 + 3) begin
      failures++; $display("FAIL basic_latency got=%0d exp=%0d+/-3", delay, (19 * CPB) / 2);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL basic_byte got=%h exp=%h", g, e); end
    end
    pulse_rd();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_rd_done got=%b exp=0", done); end
    $display("[%0d] basic frame 0x75 latency=%0d", cyc, delay);
  endtask

  task automatic test_glitch();
    bit seen_busy = 1'b0;
    int fell_at = 0;
    exp_q.delete(); got_q.delete();
    rx = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
      if (seen_busy && !busy && fell_at == 0) fell_at = i;
      if (i == 100) rx = 1'b1;
    end
    checks++; if (!seen_busy) begin failures++; $display("FAIL glitch_busy_seen got=0 exp=1"); end
    checks++;
    if (fell_at == 0 || fell_at > 220) begin
      failures++; $display("FAIL glitch_busy_fall got=%0d exp=1..220", fell_at);
    end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL glitch_done got=%b exp=0", done); end
    checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL glitch_ferr got=%b exp=0", ferr); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL glitch_bytes got=%0d exp=0", got_q.size()); end
    $display("[%0d] glitch rejected, busy fell after %0d cycles", cyc, fell_at);
  endtask

  task automatic test_frame_err();
    exp_q.delete(); got_q.delete();
    send_frame(8'h1B, 1'b0);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checks++; if (ferr !== 1'b1) begin failures++; $display("FAIL ferr_flag got=%b exp=1", ferr); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL ferr_done got=%b exp=0", done); end
    checks++; if (dat !== 8'h75) begin failures++; $display("FAIL ferr_dat got=%h exp=75", dat); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_busy got=%b exp=0", busy); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL ferr_bytes got=%0d exp=0", got_q.size()); end
    pulse_rd();
    checks++; if (ferr !== 1'b1) begin failures++; $display("FAIL ferr_rd_no_done got=%b exp=1", ferr); end
    $display("[%0d] framing error frame 0x1B", cyc);
  endtask

  task automatic test_back_to_back();
    logic [7:0] e, g;
    exp_q.delete(); got_q.delete();
    send_frame(8'h1B, 1'b1);
    send_frame(8'h1E, 1'b1);
    repeat (CPB) @(negedge clk);
    checks++; if (dat !== 8'h1E) begin failures++; $display("FAIL b2b_dat got=%h exp=1e", dat); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", done); end
    checks++; if (ovr !== 1'b1) begin failures++; $display("FAIL b2b_ovr got=%b exp=1", ovr); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL b2b_byte got=%h exp=%h", g, e); end
    end
    pulse_rd();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_rd_done got=%b exp=0", done); end
    checks++; if (ovr !== 1'b0) begin failures++; $display("FAIL b2b_rd_ovr got=%b exp=0", ovr); end
    checks++; if (ferr !== 1'b0) begin failures++; $display("FAIL b2b_rd_ferr got=%b exp=0", ferr); end
    $display("[%0d] back-to-back 0x1B,0x1E", cyc);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] e, g;
    int rises_before;
    logic [7:0] partial;
    partial = 8'h75;
    exp_q.delete(); got_q.delete();
    rises_before = done_rises;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(partial[i]);
    rx = partial[4];
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (dat !== 8'h00) begin failures++; $display("FAIL midrst_dat got=%h exp=00", dat); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rx = 1'b1;
    repeat (10 * CPB) @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_no_done got=%b exp=0", done); end
    send_frame(8'h1E, 1'b1);
    repeat (CPB) @(negedge clk);
    checks++; if (dat !== 8'h1E) begin failures++; $display("FAIL midrst_dat2 got=%h exp=1e", dat); end
    checks++;
    if (done_rises - rises_before != 1) begin
      failures++; $display("FAIL midrst_done_pulses got=%0d exp=1", done_rises - rises_before);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL midrst_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL midrst_byte got=%h exp=%h", g, e); end
    end
    pulse_rd();
    $display("[%0d] reset mid-frame then 0x1E", cyc);
  endtask

  task automatic test_break();
    logic [7:0] e, g;
    exp_q.delete(); got_q.delete();
    rx = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    checks++; if (ferr !== 1'b1) begin failures++; $display("FAIL break_ferr got=%b exp=1", ferr); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL break_busy got=%b exp=1", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL break_done got=%b exp=0", done); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL break_release got=%b exp=0", busy); end
    repeat (CPB) @(negedge clk);
    send_frame(8'h75, 1'b1);
    repeat (CPB) @(negedge clk);
    checks++; if (dat !== 8'h75) begin failures++; $display("FAIL break_dat got=%h exp=75", dat); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL break_done2 got=%b exp=1", done); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL break_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL break_byte got=%h exp=%h", g, e); end
    end
    $display("[%0d] break then 0x75", cyc);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_break();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
